// File: rtl/loader_pkg.sv
// loader_pkg
// Shared definitions for the syndrome stream loader.
//   - loader_state_t : frame-loader FSM states
//   - WORD_W         : stream word width
//   - frame_words()  : number of payload words in a frame, for a given
//                      PU_COUNT and packing mode
package loader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } loader_state_t;

    // Packed frames carry WORD_W syndromes per word, with the last word
    // padded. Unpacked frames carry one syndrome per word.
    function automatic int frame_words(input int pu_count, input bit packed_mode);
        if (packed_mode) begin
            return (pu_count + WORD_W - 1) / WORD_W;
        end
        return pu_count;
    endfunction

endpackage

// File: rtl/syndrome_stream_loader_popcount_acc.sv
// popcount_acc
// Running count of set bits over the accepted payload words of one frame.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count at zero (header accepted)
//   accept       : add the ones of 'word' this cycle
//   word         : payload bits to count (bits that do not carry a
//                  syndrome are already masked to zero by the caller)
//   count        : accumulated number of set bits
module popcount_acc
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [WORD_W-1:0] word,
    output logic [31:0]       count
);

    logic [5:0] ones;

    // Count the ones in the current word. Six bits hold up to 32.
    always_comb begin
        ones = '0;
        for (int b = 0; b < WORD_W; b++) begin
            ones = ones + 6'(word[b]);
        end
    end

    // Accumulate across the frame. A clear takes priority over an add.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 32'(ones);
        end
    end

endmodule

// File: rtl/syndrome_stream_loader.sv
// syndrome_stream_loader
// Receives syndrome frames from a valid/ready stream and loads them into the
// decoder's syndrome vector. A frame is one header word (the test ID)
// followed by the payload words. The completed frame is presented with a
// one-cycle start pulse. The loader then waits for the decoder to finish.
//
// Build option: define SYNDROME_PACKED_EN to pack 32 syndromes per payload
// word (LSB = lowest index). Otherwise each payload word carries one syndrome
// in bit 0, and a word with nonzero upper bits sets format_error.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   s_data/s_valid     : input stream word and valid
//   s_ready            : stream ready (IDLE and LOAD only, never in reset)
//   is_error_syndromes : syndrome vector presented to the decoder
//   new_round_start    : one-cycle decoder start pulse
//   result_valid       : decoder result, ends the WAIT state
//   deadlock           : decoder deadlock, ends the WAIT state
//   test_id            : header of the current frame
//   syndrome_count     : number of set syndromes in the frame
//   busy               : decode in flight
//   format_error       : sticky malformed-payload flag
module syndrome_stream_loader
    import loader_pkg::*;
#(
    parameter  int CODE_DISTANCE_X    = 3,
    parameter  int CODE_DISTANCE_Z    = 2,
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                        CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z *
                                        MEASUREMENT_ROUNDS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [PU_COUNT-1:0] is_error_syndromes,
    output logic                new_round_start,
    input  logic                result_valid,
    input  logic                deadlock,
    output logic [31:0]         test_id,
    output logic [31:0]         syndrome_count,
    output logic                busy,
    output logic                format_error
);

`ifdef SYNDROME_PACKED_EN
    localparam int FRAME_WORDS = frame_words(PU_COUNT, 1'b1);
`else
    localparam int FRAME_WORDS = frame_words(PU_COUNT, 1'b0);
`endif
    localparam logic [31:0] LAST_WORD = 32'(FRAME_WORDS - 1);

    loader_state_t       state;
    loader_state_t       state_next;
    logic                running;
    logic [31:0]         word_cnt;
    logic [PU_COUNT-1:0] shadow;
    logic [PU_COUNT-1:0] shadow_next;
    logic [WORD_W-1:0]   count_word;
    logic                payload_bad;
    logic                accept;
    logic                last_word;
`ifdef SYNDROME_PACKED_EN
    logic [31:0]         word_base;
`endif

    // 'running' keeps s_ready low until the first clock edge after reset.
    assign s_ready         = running && ((state == IDLE) || (state == LOAD));
    assign accept          = s_valid && s_ready;
    assign last_word       = (word_cnt == LAST_WORD);
    assign new_round_start = (state == START);
    assign busy            = (state == WAIT);

    // Decode the current payload word. This gives the shadow vector with the
    // word merged in, the bits that carry syndromes (for counting), and the
    // malformed-word flag.
    always_comb begin
        shadow_next = shadow;
        count_word  = '0;
        payload_bad = 1'b0;
`ifdef SYNDROME_PACKED_EN
        word_base = word_cnt << 5;
        for (int b = 0; b < WORD_W; b++) begin
            count_word[b] = s_data[b] & ((word_base + 32'(b)) < 32'(PU_COUNT));
        end
        for (int i = 0; i < PU_COUNT; i++) begin
            if (word_cnt == 32'(i / WORD_W)) begin
                shadow_next[i] = s_data[5'(i % WORD_W)];
            end
        end
`else
        count_word[0] = s_data[0];
        payload_bad   = |s_data[WORD_W-1:1];
        for (int i = 0; i < PU_COUNT; i++) begin
            if (word_cnt == 32'(i)) begin
                shadow_next[i] = s_data[0];
            end
        end
`endif
    end

    // Next-state logic. Decoder responses only matter in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    if (accept && last_word) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (result_valid || deadlock) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and frame registers. The decoder vector is loaded on the last
    // payload handshake, so it is already stable in the START cycle that
    // carries the start pulse. It then holds until the next frame completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            running            <= 1'b0;
            word_cnt           <= '0;
            shadow             <= '0;
            is_error_syndromes <= '0;
            test_id            <= '0;
            format_error       <= 1'b0;
        end else begin
            state   <= state_next;
            running <= 1'b1;
            if (state == IDLE && accept) begin
                test_id  <= s_data;
                word_cnt <= '0;
                shadow   <= '0;
            end
            if (state == LOAD && accept) begin
                shadow   <= shadow_next;
                word_cnt <= word_cnt + 32'd1;
                if (payload_bad) begin
                    format_error <= 1'b1;
                end
                if (last_word) begin
                    is_error_syndromes <= shadow_next;
                end
            end
        end
    end

    popcount_acc u_popcount_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((state == IDLE) && accept),
        .accept  ((state == LOAD) && accept),
        .word    (count_word),
        .count   (syndrome_count)
    );

endmodule

// File: tb/tb_syndrome_stream_loader.sv
// tb_syndrome_stream_loader
// Self-checking bench for syndrome_stream_loader. Frames use random syndrome
// vectors, random bubbles, and random ignored decoder responses during LOAD.
// The expected values come from the frame contents: the vector itself, its
// population count, the header, and a sticky format flag.
// Honours SYNDROME_PACKED_EN in the same way as the design.
module tb_syndrome_stream_loader;

    localparam int X      = 3;
    localparam int Z      = 2;
    localparam int ROUNDS = (X > Z) ? X : Z;
    localparam int PU     = X * Z * ROUNDS;
`ifdef SYNDROME_PACKED_EN
    localparam int WORDS  = (PU + 31) / 32;
`else
    localparam int WORDS  = PU;
`endif

    logic          clk;
    logic          reset_n;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [PU-1:0] is_error_syndromes;
    logic          new_round_start;
    logic          result_valid;
    logic          deadlock;
    logic [31:0]   test_id;
    logic [31:0]   syndrome_count;
    logic          busy;
    logic          format_error;

    int  checks;
    int  errors;
    int  pulses;
    int  exp_pulses;
    bit  exp_fmt;
    bit  ready_seen;

    syndrome_stream_loader #(
        .CODE_DISTANCE_X (X),
        .CODE_DISTANCE_Z (Z)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .is_error_syndromes (is_error_syndromes),
        .new_round_start    (new_round_start),
        .result_valid       (result_valid),
        .deadlock           (deadlock),
        .test_id            (test_id),
        .syndrome_count     (syndrome_count),
        .busy               (busy),
        .format_error       (format_error)
    );

    always #5 clk = ~clk;

    // s_ready only changes at rising edges or on reset, so the value seen
    // at the falling edge is the value that qualifies the next rising edge.
    always @(negedge clk) ready_seen = s_ready;

    // Count start pulses, one for each cycle in which the pulse is high.
    always @(posedge clk) if (reset_n && new_round_start) pulses++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word and wait for its handshake. Returns after the
    // accepting edge, with 'waited' giving the number of refused edges.
    task automatic sendWord(input logic [31:0] data, output int waited);
        bit done;
        done   = 0;
        waited = 0;
        s_valid = 1'b1;
        s_data  = data;
        while (!done && waited < 64) begin
            @(posedge clk);
            if (ready_seen) done = 1;
            else waited++;
        end
        #1;
        s_valid = 1'b0;
        if (!done) checkOutput("handshake_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] buildWord(input logic [PU-1:0] vec, input int n, input bit junk);
        logic [31:0] w;
        w = '0;
`ifdef SYNDROME_PACKED_EN
        for (int b = 0; b < 32; b++) begin
            int idx;
            idx = n * 32 + b;
            if (idx < PU) w[b] = vec[idx];
            else if (junk) w[b] = 1'($urandom_range(0, 1));
        end
`else
        w[0] = vec[n];
        if (junk) w[31:1] = (n == 0) ? 31'd1 : 31'($urandom_range(1, 32'h7fff_ffff));
`endif
        return w;
    endfunction

    // Send a frame (header, then payload with bubbles). Check the START cycle
    // and the first WAIT cycle. Returns just after the WAIT falling edge.
    task automatic applyStimulus(input logic [31:0] hdr, input logic [PU-1:0] vec,
                                 input bit junk, input bit preloaded);
        int waited;
        sendWord(hdr, waited);
        if (preloaded) checkOutput("hdr_first_idle_cycle", 64'(waited), 64'd0);
`ifndef SYNDROME_PACKED_EN
        if (junk) exp_fmt = 1;
`endif
        for (int n = 0; n < WORDS; n++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                result_valid = 1'($urandom_range(0, 1));
                deadlock     = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                result_valid = 1'b0;
                deadlock     = 1'b0;
            end
            sendWord(buildWord(vec, n, junk), waited);
        end
        exp_pulses++;
        @(negedge clk);
        checkOutput("start_pulse", 64'(new_round_start), 64'd1);
        checkOutput("start_syndromes", 64'(is_error_syndromes), 64'(vec));
        checkOutput("start_count", 64'(syndrome_count), 64'($countones(vec)));
        checkOutput("start_test_id", 64'(test_id), 64'(hdr));
        checkOutput("start_busy", 64'(busy), 64'd0);
        checkOutput("start_ready", 64'(s_ready), 64'd0);
        checkOutput("format_error", 64'(format_error), 64'(exp_fmt));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("wait_pulse_low", 64'(new_round_start), 64'd0);
        checkOutput("wait_busy", 64'(busy), 64'd1);
        checkOutput("wait_ready", 64'(s_ready), 64'd0);
        checkOutput("wait_syndromes", 64'(is_error_syndromes), 64'(vec));
    endtask

    // Keep WAIT for 'hold' cycles, then end it with result_valid or deadlock.
    // Returns at the falling edge of the first IDLE cycle.
    task automatic releaseWait(input int hold, input bit use_deadlock,
                               input logic [PU-1:0] vec, input logic [31:0] hdr);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("wait_hold_busy", 64'(busy), 64'd1);
            checkOutput("wait_hold_ready", 64'(s_ready), 64'd0);
        end
        if (use_deadlock) deadlock = 1'b1;
        else result_valid = 1'b1;
        @(posedge clk);
        #1;
        deadlock     = 1'b0;
        result_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_ready", 64'(s_ready), 64'd1);
        checkOutput("idle_syndromes_held", 64'(is_error_syndromes), 64'(vec));
        checkOutput("idle_count_held", 64'(syndrome_count), 64'($countones(vec)));
        checkOutput("idle_test_id_held", 64'(test_id), 64'(hdr));
        checkOutput("pulse_count", 64'(pulses), 64'(exp_pulses));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 64'(s_ready), 64'd0);
        checkOutput({tag, "_pulse"}, 64'(new_round_start), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_fmt"}, 64'(format_error), 64'd0);
        checkOutput({tag, "_syndromes"}, 64'(is_error_syndromes), 64'd0);
        checkOutput({tag, "_count"}, 64'(syndrome_count), 64'd0);
        checkOutput({tag, "_test_id"}, 64'(test_id), 64'd0);
    endtask

    initial begin
        logic [PU-1:0] vec;
        logic [31:0]   hdr;
        int            waited;
        clk = 1'b0; reset_n = 1'b0; s_valid = 1'b0; s_data = '0;
        result_valid = 1'b0; deadlock = 1'b0;
        checks = 0; errors = 0; pulses = 0; exp_pulses = 0; exp_fmt = 0;

        #12;
        checkResetOutputs("reset");
        #5 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_first_edge", 64'(s_ready), 64'd0);
        @(negedge clk);
        checkOutput("ready_after_first_edge", 64'(s_ready), 64'd1);

        // All-zero frame, ended by result_valid.
        vec = '0;
        applyStimulus(32'h5, vec, 0, 0);
        releaseWait(3, 0, vec, 32'h5);

        // Syndromes at indices 3 and 17, ended by deadlock.
        vec = '0; vec[3] = 1'b1; vec[17] = 1'b1;
        applyStimulus(32'h7, vec, 0, 0);
        checkOutput("idx3_17_vector", 64'(vec), 64'h20008);
        releaseWait(1, 1, vec, 32'h7);

        // A header presented during WAIT is held off, then accepted in the
        // first IDLE cycle.
        vec = PU'($urandom);
        applyStimulus(32'hA1, vec, 0, 0);
        s_valid = 1'b1;
        s_data  = 32'hB2;
        releaseWait(3, 0, vec, 32'hA1);
        vec = PU'($urandom);
        applyStimulus(32'hB2, vec, 0, 1);
        releaseWait(0, 1, vec, 32'hB2);

        // Malformed words: the first payload word is 0x3 when unpacked.
        vec = PU'($urandom); vec[0] = 1'b1;
        applyStimulus(32'h30, vec, 1, 0);
        releaseWait(1, 0, vec, 32'h30);

        // Reset in the middle of LOAD drops the partial frame.
        sendWord(32'h99, waited);
        for (int n = 0; n < WORDS && n < 3; n++) sendWord(32'h1, waited);
        #2 reset_n = 1'b0;
        #1;
        checkResetOutputs("midload_reset");
        exp_fmt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int f = 0; f < 8; f++) begin
            vec = PU'($urandom);
            hdr = $urandom;
            applyStimulus(hdr, vec, 0, 0);
            releaseWait($urandom_range(0, 3), 1'($urandom_range(0, 1)), vec, hdr);
        end

        // All-ones frame (a single 0xFFFFFFFF-style word when packed).
        vec = '1;
        applyStimulus(32'hFF, vec, 1, 0);
        checkOutput("all_ones_count", 64'(syndrome_count), 64'(PU));
        releaseWait(1, 0, vec, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
